fault_cam_collector: RTL and testbench
======================================

Name: fault_cam_collector

Overview:
Upstream feeder of the spare allocation analyzer. Accepts faulty-cell coordinates streamed from the BIST comparator, one per cycle, and classifies each one. A fault sharing neither row nor column with a stored pivot becomes a pivot; a fault sharing one becomes a non-pivot linked to that pivot; exact repeats are dropped. It holds the PCAM and NPCAM images that the analyzer reads, and flags early termination when either CAM overflows, which means the die is unrepairable.

Parameters:
PCAM, 8, pivot CAM entries (total spare rows + spare cols)
NPCAM, 30, non-pivot CAM entries
PTR_W, 5, pivot pointer width in an NPCAM entry; PCAM <= 2**PTR_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; clears both CAMs and begins collection
fault_valid  input  1  fault coordinate present
fault_row  input  10  faulty row address
fault_col  input  10  faulty column address
fault_ready  output  1  collector accepts a fault this cycle
bist_done  input  1  BIST sweep finished; no more faults
pivot_fault_addr  output  26 x [0:PCAM-1]  PCAM image: [25] valid, [24:15] row, [14:5] col, [4:0] linked non-pivot count (saturating at 31)
nonpivot_fault_addr  output  17 x [0:NPCAM-1]  NPCAM image: [16] valid, [15:11] pivot pointer, [10] share type (0 = shares row, 1 = shares col), [9:0] non-shared coordinate
pivot_count  output  $clog2(PCAM+1)  valid PCAM entries
nonpivot_count  output  $clog2(NPCAM+1)  valid NPCAM entries
collect_done  output  1  level; CAMs are final and can be analysed
early_term  output  1  level; CAM overflow, unrepairable

Behaviour:
- Reset (async, rst=1): all CAM entries are all-zero, counts are 0, and state is IDLE. In IDLE, fault_ready=0, collect_done=0 and early_term=0. A reset asserted mid-collection discards everything.
- FSM states: IDLE, COLLECT, DONE, TERM.
  - IDLE -> COLLECT on start.
  - COLLECT -> DONE on bist_done, when no overflow occurs in the same cycle.
  - COLLECT -> TERM on overflow. Overflow takes priority over a simultaneous bist_done.
  - DONE/TERM -> COLLECT on start.
  - start in any state clears the CAMs and counts on that edge and enters COLLECT.
- fault_ready = 1 only in COLLECT. A fault is accepted when fault_valid & fault_ready. A fault arriving in the same cycle as start is ignored.
- Classification is combinational against the registered CAM contents. The CAM update is visible on the next clock edge, so latency is 1 cycle. Back-to-back faults must see the previous fault's update: the CAMs are registered and classification uses the current contents, so no hazard exists.
- Row-match vector: valid pivots with row == fault_row. Column-match vector: valid pivots with col == fault_col. The lowest matching index wins.
- Classification rules, in priority order:
  1. Some pivot matches both row and col -> duplicate; drop it, no state change.
  2. Any row match -> candidate non-pivot {ptr=lowest row-match idx, type=0, addr=fault_col}.
  3. Else any col match -> candidate non-pivot {ptr=lowest col-match idx, type=1, addr=fault_row}.
  4. Else -> new pivot.
- A non-pivot candidate equal to an existing valid NPCAM entry (bits [15:0]) is a duplicate and is dropped. Otherwise it is written to the lowest free NPCAM slot, nonpivot_count increments, and the linked pivot's [4:0] increments, saturating at 31.
- A new pivot is written to the lowest free PCAM slot with count 0, and pivot_count increments.
- Overflow: a new pivot with PCAM full, or a new non-pivot with NPCAM full. The fault is not stored, the FSM enters TERM, and early_term=1.
- collect_done=1 in DONE. early_term=1 in TERM. Both hold until start or rst.
- CAM outputs are driven directly from registers and stay stable in DONE/TERM.

Test Plan:
- Reset, start, then faults (5,7), (5,9), (3,7) -> PCAM[0]={1,5,7,2}; NPCAM[0]={1,0,0,9}, NPCAM[1]={1,0,1,3}; pivot_count=1, nonpivot_count=2.
- Feed (5,7) twice and (5,9) twice -> one pivot, one non-pivot; counts 1/1 and PCAM[0][4:0]=1.
- Feed 9 faults with distinct rows and columns (PCAM=8) -> 8 pivots stored; on the 9th, early_term=1 the next cycle, fault_ready=0, pivot_count=8.
- bist_done in the same cycle as an overflowing fault -> TERM (early_term=1), collect_done=0.
- After DONE with 3 pivots, pulse start -> all valid bits 0 and counts 0 the next cycle, fault_ready=1. Assert rst mid-stream -> all outputs reach reset values immediately, without waiting for a clock edge.
- Fault (2,4) with pivots P0=(2,8) and P1=(6,4) -> row priority: NPCAM entry {ptr=0, type=0, addr=4}, and P0 count increments.

Source files
------------

// File: rtl/fault_cam_collector_if.sv
// fault_cam_collector_if
//   Bundles the BIST fault stream and the collector's CAM image outputs.
//   master : BIST side / analyzer side (drives start, fault stream, bist_done;
//            observes ready, CAM images, counts and status)
//   slave  : the collector itself
//   Signals:
//     start               one-cycle pulse, clears CAMs and begins collection
//     fault_valid/row/col faulty-cell coordinate stream
//     fault_ready         collector accepts a fault this cycle
//     bist_done           BIST sweep finished
//     pivot_fault_addr    PCAM image {valid, row, col, linked count}
//     nonpivot_fault_addr NPCAM image {valid, pivot ptr, share type, addr}
//     pivot_count/nonpivot_count  number of valid entries
//     collect_done/early_term     status levels
interface fault_cam_collector_if #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 30,
    parameter int PTR_W = 5
);
    localparam int PC_W = $clog2(PCAM + 1);
    localparam int NC_W = $clog2(NPCAM + 1);
    localparam int NE_W = PTR_W + 12;

    logic              start;
    logic              fault_valid;
    logic [9:0]        fault_row;
    logic [9:0]        fault_col;
    logic              fault_ready;
    logic              bist_done;
    logic [25:0]       pivot_fault_addr    [0:PCAM-1];
    logic [NE_W-1:0]   nonpivot_fault_addr [0:NPCAM-1];
    logic [PC_W-1:0]   pivot_count;
    logic [NC_W-1:0]   nonpivot_count;
    logic              collect_done;
    logic              early_term;

    modport master (
        output start, fault_valid, fault_row, fault_col, bist_done,
        input  fault_ready, pivot_fault_addr, nonpivot_fault_addr,
               pivot_count, nonpivot_count, collect_done, early_term
    );

    modport slave (
        input  start, fault_valid, fault_row, fault_col, bist_done,
        output fault_ready, pivot_fault_addr, nonpivot_fault_addr,
               pivot_count, nonpivot_count, collect_done, early_term
    );
endinterface

// File: rtl/fault_cam_collector.sv
// fault_cam_collector
//   Classifies streamed faulty-cell coordinates into pivot (PCAM) and
//   non-pivot (NPCAM) entries for the spare allocation analyzer. A fault that
//   shares neither row nor column with a stored pivot becomes a pivot; one
//   sharing a row (preferred) or column becomes a non-pivot linked to the
//   lowest-index matching pivot; exact repeats are dropped. Overflow of either
//   CAM flags early termination (die unrepairable).
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  fault_cam_collector_if.slave (fault stream in, CAM images out)
module fault_cam_collector #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 30,
    parameter int PTR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    fault_cam_collector_if.slave  bus
);
    localparam int PI_W = (PCAM  > 1) ? $clog2(PCAM)  : 1;
    localparam int NI_W = (NPCAM > 1) ? $clog2(NPCAM) : 1;
    localparam int PC_W = $clog2(PCAM + 1);
    localparam int NC_W = $clog2(NPCAM + 1);
    localparam int NE_W = PTR_W + 12;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, TERM} state_t;

    state_t          state;
    logic [25:0]     pcam  [0:PCAM-1];
    logic [NE_W-1:0] npcam [0:NPCAM-1];
    logic [PC_W-1:0] pcnt;
    logic [NC_W-1:0] npcnt;
    logic            ready_r, done_r, term_r;

    // Pivot match / free-slot search against the registered PCAM.
    logic            row_hit, col_hit, both_hit, p_free;
    logic [PI_W-1:0] row_idx, col_idx, p_free_idx;

    // NOTE: every always_comb output gets a default before the loops, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        row_hit    = 1'b0;
        col_hit    = 1'b0;
        both_hit   = 1'b0;
        p_free     = 1'b0;
        row_idx    = '0;
        col_idx    = '0;
        p_free_idx = '0;
        // Scan downward so the lowest matching index is the last one written.
        for (int i = PCAM - 1; i >= 0; i--) begin
            if (pcam[i][25]) begin
                if (pcam[i][24:15] == bus.fault_row) begin
                    row_hit = 1'b1;
                    row_idx = PI_W'(i);
                end
                if (pcam[i][14:5] == bus.fault_col) begin
                    col_hit = 1'b1;
                    col_idx = PI_W'(i);
                end
                if (pcam[i][24:15] == bus.fault_row && pcam[i][14:5] == bus.fault_col)
                    both_hit = 1'b1;
            end else begin
                p_free     = 1'b1;
                p_free_idx = PI_W'(i);
            end
        end
    end

    // Non-pivot candidate: row sharing wins over column sharing.
    logic [PI_W-1:0] link_idx;
    logic [NE_W-2:0] cand;
    assign link_idx = row_hit ? row_idx : col_idx;
    assign cand     = row_hit ? {PTR_W'(row_idx), 1'b0, bus.fault_col}
                              : {PTR_W'(col_idx), 1'b1, bus.fault_row};

    logic            np_dup, np_free;
    logic [NI_W-1:0] np_free_idx;

    always_comb begin
        np_dup      = 1'b0;
        np_free     = 1'b0;
        np_free_idx = '0;
        for (int j = NPCAM - 1; j >= 0; j--) begin
            if (npcam[j][NE_W-1]) begin
                if (npcam[j][NE_W-2:0] == cand)
                    np_dup = 1'b1;
            end else begin
                np_free     = 1'b1;
                np_free_idx = NI_W'(j);
            end
        end
    end

    logic accept, is_pivot, is_np, np_new, overflow;
    // A fault in the same cycle as start is ignored.
    assign accept   = bus.fault_valid && state == COLLECT && !bus.start;
    assign is_pivot = !row_hit && !col_hit;
    assign is_np    = (row_hit || col_hit) && !both_hit;
    assign np_new   = is_np && !np_dup;
    assign overflow = accept && ((is_pivot && !p_free) || (np_new && !np_free));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    // NOTE: the CAM arrays are flops (they drive the analyzer directly and
    // must read all-zero after reset), so they are reset like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pcnt    <= '0;
            npcnt   <= '0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            term_r  <= 1'b0;
            for (int i = 0; i < PCAM; i++)  pcam[i]  <= '0;
            for (int j = 0; j < NPCAM; j++) npcam[j] <= '0;
        end else if (bus.start) begin
            state   <= COLLECT;
            pcnt    <= '0;
            npcnt   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            term_r  <= 1'b0;
            for (int i = 0; i < PCAM; i++)  pcam[i]  <= '0;
            for (int j = 0; j < NPCAM; j++) npcam[j] <= '0;
        end else if (state == COLLECT) begin
            if (overflow) begin
                // Overflowing fault is not stored and beats bist_done.
                state   <= TERM;
                ready_r <= 1'b0;
                term_r  <= 1'b1;
            end else begin
                if (accept && is_pivot) begin
                    pcam[p_free_idx] <= {1'b1, bus.fault_row, bus.fault_col, 5'd0};
                    pcnt             <= pcnt + PC_W'(1);
                end
                if (accept && np_new) begin
                    npcam[np_free_idx] <= {1'b1, cand};
                    npcnt              <= npcnt + NC_W'(1);
                    if (pcam[link_idx][4:0] != 5'd31)
                        pcam[link_idx][4:0] <= pcam[link_idx][4:0] + 5'd1;
                end
                if (bus.bist_done) begin
                    state   <= DONE;
                    ready_r <= 1'b0;
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign bus.pivot_fault_addr    = pcam;
    assign bus.nonpivot_fault_addr = npcam;
    assign bus.pivot_count         = pcnt;
    assign bus.nonpivot_count      = npcnt;
    assign bus.fault_ready         = ready_r;
    assign bus.collect_done        = done_r;
    assign bus.early_term          = term_r;
endmodule

// File: tb/tb_fault_cam_collector.sv
// tb_fault_cam_collector
//   Directed bench for fault_cam_collector. A list-based model (pivot and
//   non-pivot lists plus a mode) is stepped once per clock by the driver and
//   compared against every DUT output on each falling edge; literal checks pin
//   the model at the scenario boundaries.
module tb_fault_cam_collector;
    localparam int PCAM  = 8;
    localparam int NPCAM = 30;
    localparam int PTR_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fault_cam_collector_if #(.PCAM(PCAM), .NPCAM(NPCAM), .PTR_W(PTR_W)) bus ();

    fault_cam_collector #(.PCAM(PCAM), .NPCAM(NPCAM), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model: 0 idle, 1 collect, 2 done, 3 term
    int m_mode;
    int mp_n, mn_n;
    int mp_row [PCAM];
    int mp_col [PCAM];
    int mp_cnt [PCAM];
    int mn_ptr [NPCAM];
    int mn_typ [NPCAM];
    int mn_adr [NPCAM];

    function automatic void model_reset();
        m_mode = 0;
        mp_n   = 0;
        mn_n   = 0;
    endfunction

    function automatic void model_step(bit st, bit v, int r, int c, bit dn);
        int  ptr, typ, adr;
        bit  dup, ovf;
        if (st) begin
            mp_n = 0; mn_n = 0; m_mode = 1;
            return;
        end
        if (m_mode != 1) return;
        if (v) begin
            ptr = -1; typ = 0; adr = 0; dup = 0; ovf = 0;
            for (int i = 0; i < mp_n; i++)
                if (mp_row[i] == r && mp_col[i] == c) dup = 1;
            for (int i = 0; i < mp_n; i++)
                if (ptr < 0 && mp_row[i] == r) begin ptr = i; typ = 0; adr = c; end
            for (int i = 0; i < mp_n; i++)
                if (ptr < 0 && mp_col[i] == c) begin ptr = i; typ = 1; adr = r; end
            if (!dup) begin
                if (ptr < 0) begin
                    if (mp_n == PCAM) ovf = 1;
                    else begin
                        mp_row[mp_n] = r; mp_col[mp_n] = c; mp_cnt[mp_n] = 0;
                        mp_n++;
                    end
                end else begin
                    for (int j = 0; j < mn_n; j++)
                        if (mn_ptr[j] == ptr && mn_typ[j] == typ && mn_adr[j] == adr) dup = 1;
                    if (!dup) begin
                        if (mn_n == NPCAM) ovf = 1;
                        else begin
                            mn_ptr[mn_n] = ptr; mn_typ[mn_n] = typ; mn_adr[mn_n] = adr;
                            mn_n++;
                            if (mp_cnt[ptr] < 31) mp_cnt[ptr]++;
                        end
                    end
                end
            end
            if (ovf) begin
                m_mode = 3;
                return;
            end
        end
        if (dn) m_mode = 2;
    endfunction

    function automatic logic [25:0] exp_p(int i);
        if (i < mp_n) return {1'b1, 10'(mp_row[i]), 10'(mp_col[i]), 5'(mp_cnt[i])};
        return '0;
    endfunction

    function automatic logic [16:0] exp_n(int j);
        if (j < mn_n) return {1'b1, 5'(mn_ptr[j]), 1'(mn_typ[j]), 10'(mn_adr[j])};
        return '0;
    endfunction

    // ---------------- compare process
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < PCAM; i++)
                check($sformatf("pcam[%0d]", i), 32'(bus.pivot_fault_addr[i]), 32'(exp_p(i)));
            for (int j = 0; j < NPCAM; j++)
                check($sformatf("npcam[%0d]", j), 32'(bus.nonpivot_fault_addr[j]), 32'(exp_n(j)));
            check("pivot_count",    32'(bus.pivot_count),    32'(mp_n));
            check("nonpivot_count", 32'(bus.nonpivot_count), 32'(mn_n));
            check("fault_ready",    32'(bus.fault_ready),    32'(m_mode == 1));
            check("collect_done",   32'(bus.collect_done),   32'(m_mode == 2));
            check("early_term",     32'(bus.early_term),     32'(m_mode == 3));
        end
    end

    // ---------------- driver
    task automatic cycle(input bit st, input bit v, input int r, input int c, input bit dn);
        bus.start       = st;
        bus.fault_valid = v;
        bus.fault_row   = 10'(r);
        bus.fault_col   = 10'(c);
        bus.bist_done   = dn;
        @(posedge clk);
        model_step(st, v, r, c, dn);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.fault_valid = 1'b0;
        bus.bist_done   = 1'b0;
    endtask

    task automatic fault(input int r, input int c);
        cycle(0, 1, r, c, 0);
    endtask

    task automatic do_start();
        cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.fault_valid = 1'b0;
        bus.fault_row   = '0;
        bus.fault_col   = '0;
        bus.bist_done   = 1'b0;
        model_reset();
        cmp_en = 1;
        repeat (2) @(negedge clk);
        check("rst pivot_count", 32'(bus.pivot_count), 32'd0);
        check("rst fault_ready", 32'(bus.fault_ready), 32'd0);
        rst = 1'b0;
        cycle(0, 1, 4, 4, 0);  // IDLE: fault ignored
        check("idle ignore", 32'(bus.pivot_count), 32'd0);

        // Basic classification
        do_start();
        fault(5, 7); fault(5, 9); fault(3, 7);
        check("t1 pcam0",  32'(bus.pivot_fault_addr[0]),    32'({1'b1, 10'd5, 10'd7, 5'd2}));
        check("t1 npcam0", 32'(bus.nonpivot_fault_addr[0]), 32'({1'b1, 5'd0, 1'b0, 10'd9}));
        check("t1 npcam1", 32'(bus.nonpivot_fault_addr[1]), 32'({1'b1, 5'd0, 1'b1, 10'd3}));
        check("t1 pcnt",   32'(bus.pivot_count),    32'd1);
        check("t1 npcnt",  32'(bus.nonpivot_count), 32'd2);

        // Duplicates dropped
        do_start();
        fault(5, 7); fault(5, 7); fault(5, 9); fault(5, 9);
        check("t2 pcnt",  32'(bus.pivot_count),    32'd1);
        check("t2 npcnt", 32'(bus.nonpivot_count), 32'd1);
        check("t2 link",  32'(bus.pivot_fault_addr[0][4:0]), 32'd1);

        // PCAM overflow
        do_start();
        for (int i = 0; i < PCAM; i++) fault(i, i + 100);
        fault(50, 200);
        check("t3 term",  32'(bus.early_term),  32'd1);
        check("t3 ready", 32'(bus.fault_ready), 32'd0);
        check("t3 pcnt",  32'(bus.pivot_count), 32'd8);
        fault(60, 300);  // ignored in TERM

        // Overflow beats simultaneous bist_done
        do_start();
        for (int i = 0; i < PCAM; i++) fault(i + 10, i + 20);
        cycle(0, 1, 50, 200, 1);
        check("t4 term", 32'(bus.early_term),   32'd1);
        check("t4 done", 32'(bus.collect_done), 32'd0);

        // DONE, restart with an ignored fault, then async reset mid-stream
        do_start();
        fault(1, 1); fault(2, 2); fault(3, 3);
        cycle(0, 0, 0, 0, 1);
        check("t5 done", 32'(bus.collect_done), 32'd1);
        check("t5 pcnt", 32'(bus.pivot_count),  32'd3);
        cycle(1, 1, 70, 70, 0);
        check("t5 restart pcnt",  32'(bus.pivot_count),         32'd0);
        check("t5 restart ready", 32'(bus.fault_ready),         32'd1);
        check("t5 restart pcam0", 32'(bus.pivot_fault_addr[0]), 32'd0);
        fault(1, 1); fault(1, 2);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t5 arst pcnt",  32'(bus.pivot_count),         32'd0);
        check("t5 arst npcnt", 32'(bus.nonpivot_count),      32'd0);
        check("t5 arst pcam0", 32'(bus.pivot_fault_addr[0]), 32'd0);
        check("t5 arst ready", 32'(bus.fault_ready),         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Row sharing has priority over column sharing
        do_start();
        fault(2, 8); fault(6, 4); fault(2, 4); fault(9, 8);
        check("t6 npcam0", 32'(bus.nonpivot_fault_addr[0]), 32'({1'b1, 5'd0, 1'b0, 10'd4}));
        check("t6 p0cnt",  32'(bus.pivot_fault_addr[0][4:0]), 32'd2);
        check("t6 p1cnt",  32'(bus.pivot_fault_addr[1][4:0]), 32'd0);

        // NPCAM overflow
        do_start();
        fault(0, 0);
        for (int c = 1; c <= NPCAM; c++) fault(0, c);
        check("t7 npcnt full", 32'(bus.nonpivot_count), 32'd30);
        check("t7 link30",     32'(bus.pivot_fault_addr[0][4:0]), 32'd30);
        fault(0, 31);
        check("t7 term",  32'(bus.early_term),     32'd1);
        check("t7 npcnt", 32'(bus.nonpivot_count), 32'd30);

        repeat (2) cycle(0, 0, 0, 0, 0);
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
